// File: rtl/count8du_checker.sv
// count8du_checker: self-checking monitor beside a count8du up/down counter.
// Predicts the counter's next value from its controls, flags deviations,
// counts faults (saturating) and re-locks onto the observed value.
// Optional macro COUNT8DU_CHECKER_CAPTURE_EN adds first_exp/first_got capture
// of the first mismatch after rst.
module count8du_checker #(
   parameter int unsigned ERR_W         = 8,
   parameter bit          HOLD_ON_FAULT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctr_rst,
   input  logic             enable,
   input  logic             DIR,
   input  logic [7:0]       MAX,
   input  logic [7:0]       in,
   output logic [7:0]       expected,
   output logic             locked,
   output logic             err,
   output logic             sticky_err,
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
   output logic [7:0]       first_exp,
   output logic [7:0]       first_got,
`endif
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       expected_q, expected_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic [7:0]       pred_c;
   logic             cmp_en_c;
   logic             mism_c;
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
   logic [7:0]       first_exp_q, first_exp_d;
   logic [7:0]       first_got_q, first_got_d;
`endif

   // Next-value model of the observed counter.
   always_comb begin
      pred_c = in;
      if (ctr_rst) begin
         pred_c = 8'd0;
      end else if (!enable) begin
         pred_c = in;
      end else if (MAX == 8'd0) begin
         pred_c = 8'd0;
      end else if (DIR) begin
         pred_c = (in == MAX) ? 8'd0 : 8'(in + 8'd1);
      end else begin
         pred_c = (in == 8'd0) ? MAX : 8'(in - 8'd1);
      end
   end

   // Next-state and output logic; expected always reloads from the observed value.
   always_comb begin
      state_d     = state_q;
      expected_d  = pred_c;
      locked_d    = 1'b1;
      err_d       = 1'b0;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;
      cmp_en_c    = (state_q == TRACK) || ((state_q == FAULT) && !HOLD_ON_FAULT);
      mism_c      = cmp_en_c && (in != expected_q);
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;
`endif
      case (state_q)
         SYNC:    state_d = TRACK;
         TRACK,
         FAULT: begin
            if (cmp_en_c) state_d = mism_c ? FAULT : TRACK;
         end
         default: state_d = SYNC;
      endcase
      if (mism_c) begin
         err_d    = 1'b1;
         sticky_d = 1'b1;
         if (cnt_q != {ERR_W{1'b1}}) cnt_d = cnt_q + ERR_W'(1);
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
         if (!sticky_q) begin
            first_exp_d = expected_q;
            first_got_d = in;
         end
`endif
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SYNC;
         expected_q  <= 8'd0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
         first_exp_q <= 8'd0;
         first_got_q <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
`endif
      end
   end

   assign expected   = expected_q;
   assign locked     = locked_q;
   assign err        = err_q;
   assign sticky_err = sticky_q;
   assign err_count  = cnt_q;
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
   assign first_exp  = first_exp_q;
   assign first_got  = first_got_q;
`endif

endmodule

// File: tb/tb_count8du_checker.sv
// Directed bench for count8du_checker: default, HOLD_ON_FAULT=1 and ERR_W=2
// instances share one stimulus stream.
module tb_count8du_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ctr_rst = 1'b0;
   logic       enable = 1'b0;
   logic       DIR = 1'b0;
   logic [7:0] MAX = 8'd99;
   logic [7:0] in = 8'd0;

   logic [7:0] exp0, exp1, exp2;
   logic       lck0, lck1, lck2;
   logic       err0, err1, err2;
   logic       stk0, stk1, stk2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
   logic [7:0] fe0, fg0, fe1, fg1, fe2, fg2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count8du_checker #(.ERR_W(8), .HOLD_ON_FAULT(1'b0)) u0 (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .enable(enable), .DIR(DIR), .MAX(MAX), .in(in),
      .expected(exp0), .locked(lck0), .err(err0), .sticky_err(stk0),
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      .first_exp(fe0), .first_got(fg0),
`endif
      .err_count(cnt0));

   count8du_checker #(.ERR_W(8), .HOLD_ON_FAULT(1'b1)) u1 (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .enable(enable), .DIR(DIR), .MAX(MAX), .in(in),
      .expected(exp1), .locked(lck1), .err(err1), .sticky_err(stk1),
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      .first_exp(fe1), .first_got(fg1),
`endif
      .err_count(cnt1));

   count8du_checker #(.ERR_W(2), .HOLD_ON_FAULT(1'b0)) u2 (
      .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .enable(enable), .DIR(DIR), .MAX(MAX), .in(in),
      .expected(exp2), .locked(lck2), .err(err2), .sticky_err(stk2),
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      .first_exp(fe2), .first_got(fg2),
`endif
      .err_count(cnt2));

   // Reference counter next-value function written from the counter description.
   function automatic logic [7:0] f_ref(input logic [7:0] v, input logic en, input logic dir,
                                        input logic cr, input logic [7:0] mx);
      if (cr) return 8'd0;
      if (!en) return v;
      if (mx == 8'd0) return 8'd0;
      if (dir) return (v == mx) ? 8'd0 : v + 8'd1;
      return (v == 8'd0) ? mx : v - 8'd1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++; if (exp0 !== 8'd0) begin errors++; $display("FAIL reset_expected got %0d want 0", exp0); end
      checks++; if (lck0 !== 1'b0 || lck1 !== 1'b0 || lck2 !== 1'b0) begin errors++; $display("FAIL reset_locked got %b%b%b want 000", lck0, lck1, lck2); end
      checks++; if (err0 !== 1'b0 || stk0 !== 1'b0) begin errors++; $display("FAIL reset_err got err=%b sticky=%b want 0 0", err0, stk0); end
      checks++; if (cnt0 !== 8'd0 || cnt2 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d/%0d want 0/0", cnt0, cnt2); end
   endtask

   task automatic test_ctr_rst();
      rst = 1'b0; ctr_rst = 1'b1; enable = 1'b1; DIR = 1'b0; in = 8'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (lck0 !== 1'b1) begin errors++; $display("FAIL ctr_rst_locked cyc %0d got %b want 1", i, lck0); end
         checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL ctr_rst_err cyc %0d got %b want 0", i, err0); end
      end
      checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL ctr_rst_count got %0d want 0", cnt0); end
   endtask

   task automatic test_up();
      logic [7:0] v;
      ctr_rst = 1'b0; MAX = 8'd99; DIR = 1'b1; enable = 1'b1;
      for (int i = 0; i < 110; i++) begin
         v = (i < 100) ? 8'(i) : 8'(i - 100);
         in = v;
         step();
         checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL up_err in=%0d got %b want 0", v, err0); end
         checks++; if (exp0 !== f_ref(v, 1'b1, 1'b1, 1'b0, 8'd99)) begin errors++; $display("FAIL up_expected in=%0d got %0d want %0d", v, exp0, f_ref(v, 1'b1, 1'b1, 1'b0, 8'd99)); end
         if (i == 99) begin
            checks++; if (exp0 !== 8'd0) begin errors++; $display("FAIL up_wrap got %0d want 0", exp0); end
         end
      end
   endtask

   task automatic test_down();
      ctr_rst = 1'b1; in = 8'd10;
      step();
      ctr_rst = 1'b0; DIR = 1'b0; in = 8'd0;
      step();
      checks++; if (exp0 !== 8'd99) begin errors++; $display("FAIL down_wrap got %0d want 99", exp0); end
      for (int v = 99; v >= 1; v--) begin
         in = 8'(v);
         step();
         checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL down_err in=%0d got %b want 0", v, err0); end
         checks++; if (exp0 !== 8'(v - 1)) begin errors++; $display("FAIL down_expected in=%0d got %0d want %0d", v, exp0, v - 1); end
      end
   endtask

   task automatic test_enable();
      logic [7:0] m;
      int         i;
      m = 8'd0; DIR = 1'b1; i = 0;
      while (m != 8'd40 && i < 200) begin
         enable = ((i / 3) % 2) == 0;
         in = m;
         step();
         m = f_ref(m, enable, 1'b1, 1'b0, 8'd99);
         checks++; if (err0 !== 1'b0 || exp0 !== m) begin errors++; $display("FAIL enable_track cyc %0d got err=%b exp=%0d want 0 %0d", i, err0, exp0, m); end
         i++;
      end
      checks++; if (m !== 8'd40) begin errors++; $display("FAIL enable_reach got %0d want 40", m); end
      enable = 1'b1; in = 8'd42;
      step();
      checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL inject_err got %b want 1", err0); end
      checks++; if (cnt0 !== 8'd1 || stk0 !== 1'b1) begin errors++; $display("FAIL inject_count got cnt=%0d sticky=%b want 1 1", cnt0, stk0); end
      in = 8'd43;
      step();
      checks++; if (err0 !== 1'b0 || cnt0 !== 8'd1) begin errors++; $display("FAIL relock_43 got err=%b cnt=%0d want 0 1", err0, cnt0); end
      in = 8'd44;
      step();
      checks++; if (err0 !== 1'b0 || cnt0 !== 8'd1 || stk0 !== 1'b1) begin errors++; $display("FAIL relock_44 got err=%b cnt=%0d sticky=%b want 0 1 1", err0, cnt0, stk0); end
   endtask

   task automatic test_hold();
      logic [7:0] garbage [5];
      garbage = '{8'd7, 8'd200, 8'd3, 8'd3, 8'd77};
      for (int k = 0; k < 5; k++) begin
         in = garbage[k];
         step();
         checks++; if (cnt1 !== 8'd1 || err1 !== 1'b0 || stk1 !== 1'b1 || lck1 !== 1'b1) begin errors++; $display("FAIL hold_fault k=%0d got cnt=%0d err=%b sticky=%b lck=%b want 1 0 1 1", k, cnt1, err1, stk1, lck1); end
      end
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      checks++; if (fe0 !== 8'd40 || fg0 !== 8'd42) begin errors++; $display("FAIL capture_first got %0d/%0d want 40/42", fe0, fg0); end
`endif
      rst = 1'b1;
      step();
      checks++; if (exp1 !== 8'd0 || lck1 !== 1'b0 || err1 !== 1'b0 || stk1 !== 1'b0 || cnt1 !== 8'd0) begin errors++; $display("FAIL hold_rst got exp=%0d lck=%b err=%b sticky=%b cnt=%0d want all 0", exp1, lck1, err1, stk1, cnt1); end
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      checks++; if (fe0 !== 8'd0 || fg0 !== 8'd0) begin errors++; $display("FAIL capture_rst got %0d/%0d want 0/0", fe0, fg0); end
`endif
   endtask

   task automatic test_saturate();
      logic [1:0] want_sat [5];
      logic [7:0] bad;
      want_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      rst = 1'b0; ctr_rst = 1'b0; enable = 1'b0; in = 8'd5;
      step();
      for (int k = 0; k < 5; k++) begin
         bad = 8'(9 + k * 10);
         in = bad;
         step();
         checks++; if (err2 !== 1'b1 || cnt2 !== want_sat[k]) begin errors++; $display("FAIL sat_fault k=%0d got err=%b cnt=%0d want 1 %0d", k, err2, cnt2, want_sat[k]); end
         step();
         checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL sat_relock k=%0d got %b want 0", k, err2); end
      end
      checks++; if (cnt0 !== 8'd5) begin errors++; $display("FAIL sat_wide_count got %0d want 5", cnt0); end
`ifdef COUNT8DU_CHECKER_CAPTURE_EN
      checks++; if (fe0 !== 8'd5 || fg0 !== 8'd9) begin errors++; $display("FAIL capture_retain got %0d/%0d want 5/9", fe0, fg0); end
`endif
   endtask

   task automatic test_rst_priority();
      rst = 1'b1; in = 8'd200;
      step();
      checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0 || stk0 !== 1'b0 || lck0 !== 1'b0) begin errors++; $display("FAIL rst_priority got err=%b cnt=%0d sticky=%b lck=%b want 0 0 0 0", err0, cnt0, stk0, lck0); end
   endtask

   task automatic test_back_to_back();
      rst = 1'b0; enable = 1'b0; in = 8'd3;
      step();
      in = 8'd4;
      step();
      checks++; if (err0 !== 1'b1 || cnt0 !== 8'd1) begin errors++; $display("FAIL b2b_first got err=%b cnt=%0d want 1 1", err0, cnt0); end
      in = 8'd6;
      step();
      checks++; if (err0 !== 1'b1 || cnt0 !== 8'd2 || lck0 !== 1'b1) begin errors++; $display("FAIL b2b_second got err=%b cnt=%0d lck=%b want 1 2 1", err0, cnt0, lck0); end
      step();
      checks++; if (err0 !== 1'b0 || cnt0 !== 8'd2 || stk0 !== 1'b1) begin errors++; $display("FAIL b2b_recover got err=%b cnt=%0d sticky=%b want 0 2 1", err0, cnt0, stk0); end
   endtask

   initial begin
      test_reset();
      test_ctr_rst();
      test_up();
      test_down();
      test_enable();
      test_hold();
      test_saturate();
      test_rst_priority();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
